// File: rtl/alu_arb_pkg.sv
// Shared constants and types for the ALU round-robin arbiter.
package alu_arb_pkg;

  localparam int NUM_REQ = 16;
  localparam int IDX_W   = 4;
  localparam int TIMEOUT = 255;

  typedef logic [IDX_W-1:0] idx_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  typedef struct packed {
    logic found;
    idx_t idx;
  } pick_t;

endpackage

// File: rtl/arb_grant_decoder.sv
// 4-to-16 one-hot decoder with enable; output is all-zero when disabled.
module arb_grant_decoder
  import alu_arb_pkg::*;
(
  input  logic               i_en,
  input  idx_t               i_idx,
  output logic [NUM_REQ-1:0] o_onehot
);

  always_comb begin
    o_onehot = '0;
    if (i_en) o_onehot[i_idx] = 1'b1;
  end

endmodule

// File: rtl/alu_rr_arbiter.sv
// Round-robin arbiter sharing the ALU among 16 requesters; grant held until done.
// Optional forced release after TIMEOUT busy cycles when ARB_TIMEOUT_EN is defined.
module alu_rr_arbiter
  import alu_arb_pkg::*;
`ifdef ARB_TIMEOUT_EN
#(
  parameter int TIMEOUT = alu_arb_pkg::TIMEOUT
)
`endif
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               done,
  output logic [NUM_REQ-1:0] grant,
  output idx_t               grant_idx,
  output logic               grant_valid
`ifdef ARB_TIMEOUT_EN
  ,
  output logic               timeout_err
`endif
);

  // Search starts just after the last winner; the last winner itself comes last.
  function automatic pick_t rr_pick(input logic [NUM_REQ-1:0] req_v, input idx_t last);
    pick_t p;
    idx_t  cand;
    p = '0;
    for (int i = 1; i <= NUM_REQ; i++) begin
      cand = last + idx_t'(i);
      if (!p.found && req_v[cand]) begin
        p.found = 1'b1;
        p.idx   = cand;
      end
    end
    return p;
  endfunction

  state_t r_state;
  idx_t   r_last_idx;
  idx_t   r_grant_idx;
  logic   r_grant_valid;
  pick_t  w_pick;
  logic   w_release;

  assign w_pick = rr_pick(req, r_last_idx);

`ifdef ARB_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT + 1);

  logic [CNT_W-1:0] r_busy_cnt;
  logic             r_timeout_err;
  logic             w_timeout;
  logic             w_new_grant;

  // A done in the same cycle wins over the timeout, so no error pulse then.
  assign w_timeout   = (r_state == BUSY) && !done && (r_busy_cnt == CNT_W'(TIMEOUT - 1));
  assign w_release   = done || w_timeout;
  assign w_new_grant = w_pick.found && ((r_state == IDLE) || w_release);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_busy_cnt    <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= w_timeout;
      if (w_new_grant)
        r_busy_cnt <= '0;
      else if (r_state == BUSY)
        r_busy_cnt <= r_busy_cnt + 1'b1;
    end
  end

  assign timeout_err = r_timeout_err;
`else
  assign w_release = done;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state       <= IDLE;
      r_last_idx    <= '1;
      r_grant_idx   <= '0;
      r_grant_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_pick.found) begin
            r_state       <= BUSY;
            r_grant_idx   <= w_pick.idx;
            r_last_idx    <= w_pick.idx;
            r_grant_valid <= 1'b1;
          end
        end
        BUSY: begin
          if (w_release) begin
            if (w_pick.found) begin
              r_grant_idx <= w_pick.idx;
              r_last_idx  <= w_pick.idx;
            end else begin
              r_state       <= IDLE;
              r_grant_valid <= 1'b0;
            end
          end
        end
        default: begin
          r_state       <= IDLE;
          r_grant_valid <= 1'b0;
        end
      endcase
    end
  end

  arb_grant_decoder u_grant_decoder (
    .i_en     (r_grant_valid),
    .i_idx    (r_grant_idx),
    .o_onehot (grant)
  );

  assign grant_idx   = r_grant_idx;
  assign grant_valid = r_grant_valid;

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus random traffic
// against a behavioural model. Timeout scenario is built only with ARB_TIMEOUT_EN.
module tb_alu_rr_arbiter;

`ifdef ARB_TIMEOUT_EN
  localparam int TB_TIMEOUT = 10;
`endif

  logic        clk;
  logic        rst_n;
  logic [15:0] req;
  logic        done;
  logic [15:0] grant;
  logic [3:0]  grant_idx;
  logic        grant_valid;
`ifdef ARB_TIMEOUT_EN
  logic        timeout_err;
`endif

  int checkCount = 0;
  int passCount  = 0;

  // Behavioural model state
  int mLast;
  int mIdx;
  bit mValid;
  int mBusy;
  bit mTerr;

`ifdef ARB_TIMEOUT_EN
  alu_rr_arbiter #(.TIMEOUT(TB_TIMEOUT)) dut (
`else
  alu_rr_arbiter dut (
`endif
    .clk         (clk),
    .rst_n       (rst_n),
    .req         (req),
    .done        (done),
    .grant       (grant),
    .grant_idx   (grant_idx),
    .grant_valid (grant_valid)
`ifdef ARB_TIMEOUT_EN
    ,
    .timeout_err (timeout_err)
`endif
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // First requester in order last+1, last+2, ... (mod 16); -1 if none.
  function automatic int modelPick(input logic [15:0] r, input int last);
    for (int k = 1; k <= 16; k++) begin
      int c;
      c = (last + k) % 16;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [15:0] modelGrant();
    return mValid ? (16'h0001 << mIdx) : 16'h0000;
  endfunction

  task automatic modelReset();
    mLast  = 15;
    mIdx   = 0;
    mValid = 0;
    mBusy  = 0;
    mTerr  = 0;
  endtask

  task automatic modelStep();
    int  w;
    bit  release_now;
    bit  tmo;
    tmo = 0;
    w   = modelPick(req, mLast);
`ifdef ARB_TIMEOUT_EN
    if (mValid) begin
      mBusy = mBusy + 1;
      if (!done && mBusy == TB_TIMEOUT) tmo = 1;
    end
`endif
    release_now = done || tmo;
    if (!mValid) begin
      if (w >= 0) begin
        mValid = 1; mIdx = w; mLast = w; mBusy = 0;
      end
    end else if (release_now) begin
      if (w >= 0) begin
        mIdx = w; mLast = w; mBusy = 0;
      end else begin
        mValid = 0;
      end
    end
    mTerr = tmo;
  endtask

  task automatic tick();
    @(posedge clk);
    modelStep();
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    modelReset();
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    doReset();
    checkCount++;
    if (grant !== 16'h0000) $display("[TB] FAIL reset_grant: got %h want 0000", grant);
    else passCount++;
    checkCount++;
    if (grant_valid !== 1'b0) $display("[TB] FAIL reset_valid: got %b want 0", grant_valid);
    else passCount++;
    checkCount++;
    if (grant_idx !== 4'd0) $display("[TB] FAIL reset_idx: got %0d want 0", grant_idx);
    else passCount++;
`ifdef ARB_TIMEOUT_EN
    checkCount++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL reset_terr: got %b want 0", timeout_err);
    else passCount++;
`endif
  endtask

  task automatic test_single();
    doReset();
    req = 16'h0001;
    tick();
    checkCount++;
    if (grant !== 16'h0001 || grant_idx !== 4'd0 || grant_valid !== 1'b1)
      $display("[TB] FAIL single_grant: got %h/%0d/%b want 0001/0/1", grant, grant_idx, grant_valid);
    else passCount++;
    req  = 16'h0000;
    done = 1'b1;
    tick();
    done = 1'b0;
    checkCount++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0)
      $display("[TB] FAIL single_release: got %h/%b want 0000/0", grant, grant_valid);
    else passCount++;
  endtask

  task automatic test_rotation();
    doReset();
    req = 16'hFFFF;
    tick();
    checkCount++;
    if (grant_idx !== 4'd0 || grant !== 16'h0001)
      $display("[TB] FAIL rot_first: got %0d/%h want 0/0001", grant_idx, grant);
    else passCount++;
    for (int k = 1; k <= 16; k++) begin
      int prev;
      prev = (k - 1) % 16;
      tick();
      checkCount++;
      if (grant_idx !== 4'(prev))
        $display("[TB] FAIL rot_hold: got %0d want %0d", grant_idx, prev);
      else passCount++;
      done = 1'b1;
      tick();
      done = 1'b0;
      checkCount++;
      if (grant_idx !== 4'(k % 16) || grant !== (16'h0001 << (k % 16)) || grant_valid !== 1'b1)
        $display("[TB] FAIL rot_handover: got %0d/%h want %0d", grant_idx, grant, k % 16);
      else passCount++;
    end
    req = 16'h0000;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_wrap();
    doReset();
    req = 16'h0020;
    tick();
    checkCount++;
    if (grant_idx !== 4'd5) $display("[TB] FAIL wrap_start: got %0d want 5", grant_idx);
    else passCount++;
    req  = 16'h0021;
    done = 1'b1;
    tick();
    checkCount++;
    if (grant_idx !== 4'd0 || grant !== 16'h0001)
      $display("[TB] FAIL wrap_to0: got %0d/%h want 0/0001", grant_idx, grant);
    else passCount++;
    tick();
    done = 1'b0;
    checkCount++;
    if (grant_idx !== 4'd5 || grant !== 16'h0020)
      $display("[TB] FAIL wrap_to5: got %0d/%h want 5/0020", grant_idx, grant);
    else passCount++;
    req = 16'h0000;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

  task automatic test_drop();
    doReset();
    req = 16'h0008;
    tick();
    req = 16'h0000;
    for (int k = 0; k < 3; k++) begin
      tick();
      checkCount++;
      if (grant !== 16'h0008 || grant_valid !== 1'b1)
        $display("[TB] FAIL drop_hold: got %h/%b want 0008/1", grant, grant_valid);
      else passCount++;
    end
    done = 1'b1;
    tick();
    checkCount++;
    if (grant !== 16'h0000) $display("[TB] FAIL drop_release: got %h want 0000", grant);
    else passCount++;
    tick();
    done = 1'b0;
    checkCount++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0)
      $display("[TB] FAIL idle_done: got %h/%b want 0000/0", grant, grant_valid);
    else passCount++;
  endtask

  task automatic test_async_reset();
    doReset();
    req = 16'h0004;
    tick();
    #1;
    rst_n = 1'b0;
    #1;
    checkCount++;
    if (grant !== 16'h0000 || grant_valid !== 1'b0)
      $display("[TB] FAIL async_reset: got %h/%b want 0000/0", grant, grant_valid);
    else passCount++;
    modelReset();
    req = 16'h8001;
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    checkCount++;
    if (grant_idx !== 4'd0 || grant !== 16'h0001)
      $display("[TB] FAIL post_reset_prio: got %0d/%h want 0/0001", grant_idx, grant);
    else passCount++;
    req = 16'h0000;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask

`ifdef ARB_TIMEOUT_EN
  task automatic test_timeout();
    doReset();
    req = 16'h0004;
    tick();
    for (int k = 1; k < TB_TIMEOUT; k++) begin
      tick();
      checkCount++;
      if (timeout_err !== 1'b0 || grant !== 16'h0004)
        $display("[TB] FAIL tmo_early: cycle %0d got %b/%h want 0/0004", k, timeout_err, grant);
      else passCount++;
    end
    tick();
    checkCount++;
    if (timeout_err !== 1'b1 || grant !== 16'h0004)
      $display("[TB] FAIL tmo_fire: got %b/%h want 1/0004", timeout_err, grant);
    else passCount++;
    req = 16'h0000;
    tick();
    checkCount++;
    if (timeout_err !== 1'b0) $display("[TB] FAIL tmo_pulse: got %b want 0", timeout_err);
    else passCount++;
    done = 1'b1;
    tick();
    done = 1'b0;
  endtask
`endif

  task automatic test_random();
    doReset();
    for (int n = 0; n < 400; n++) begin
      req = 16'($urandom) & 16'($urandom) & 16'($urandom);
      if ($urandom_range(0, 3) == 0) req = 16'h0000;
      done = ($urandom_range(0, 2) == 0);
      tick();
      checkCount++;
      if (grant !== modelGrant() || grant_valid !== mValid)
        $display("[TB] FAIL rand_grant: cycle %0d got %h/%b want %h/%b", n, grant, grant_valid, modelGrant(), mValid);
      else passCount++;
      if (mValid) begin
        checkCount++;
        if (grant_idx !== 4'(mIdx))
          $display("[TB] FAIL rand_idx: cycle %0d got %0d want %0d", n, grant_idx, mIdx);
        else passCount++;
      end
`ifdef ARB_TIMEOUT_EN
      checkCount++;
      if (timeout_err !== mTerr)
        $display("[TB] FAIL rand_terr: cycle %0d got %b want %b", n, timeout_err, mTerr);
      else passCount++;
`endif
    end
    done = 1'b0;
    req  = 16'h0000;
  endtask

  initial begin
    rst_n = 1'b0;
    req   = 16'h0000;
    done  = 1'b0;
    modelReset();
    test_reset();
    test_single();
    test_rotation();
    test_wrap();
    test_drop();
    test_async_reset();
`ifdef ARB_TIMEOUT_EN
    test_timeout();
`endif
    test_random();
    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
